// File: rtl/imem_load_sequencer.sv
// Streams a host program into instruction memory, then runs the core for a bounded window.
// Optional: define IMEM_LOAD_CHECKSUM_EN to add a 32-bit XOR checksum of the words loaded.
module imem_load_sequencer #(
  parameter int ADDR_W    = 9,
  parameter int DEPTH     = 512,
  parameter int RUN_EXTRA = 2
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       in_data,
  input  logic              in_last,
  output logic [ADDR_W-1:0] addr,
  output logic              wEn,
  output logic [31:0]       wDat,
  output logic              working,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W:0]   prog_len,
  output logic              err_overflow
`ifdef IMEM_LOAD_CHECKSUM_EN
  ,
  output logic [31:0]       checksum
`endif
);

  localparam int PTR_W = ADDR_W + 1;

  typedef enum logic [2:0] {IDLE, LOAD, FLUSH, RUN, DONE} state_t;

  state_t             stateReg, stateNext;
  logic [PTR_W-1:0]   ptrReg, ptrNext;
  logic [PTR_W-1:0]   runCntReg, runCntNext;
  logic [PTR_W-1:0]   progLenReg, progLenNext;
  logic [ADDR_W-1:0]  addrReg, addrNext;
  logic [31:0]        wDatReg, wDatNext;
  logic               wEnReg, wEnNext;
  logic               workingReg, workingNext;
  logic               busyReg, busyNext;
  logic               doneReg, doneNext;
  logic               errReg, errNext;
  logic [31:0]        sumReg, sumNext;

  logic               handshake;
  logic               atCap;
  logic               lastWord;
  logic               runEnd;
  logic [PTR_W-1:0]   runLimit;

  assign in_ready  = (stateReg == LOAD);
  assign handshake = in_valid & in_ready;
  // The final slot is treated as the last word even if the host never flags it.
  assign atCap     = (ptrReg == PTR_W'(DEPTH - 1));
  assign lastWord  = in_last | atCap;
  assign runLimit  = progLenReg + PTR_W'(RUN_EXTRA) - PTR_W'(1);
  assign runEnd    = (runCntReg == runLimit);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      stateReg   <= IDLE;
      ptrReg     <= '0;
      runCntReg  <= '0;
      progLenReg <= '0;
      addrReg    <= '0;
      wDatReg    <= '0;
      wEnReg     <= 1'b0;
      workingReg <= 1'b0;
      busyReg    <= 1'b0;
      doneReg    <= 1'b0;
      errReg     <= 1'b0;
      sumReg     <= '0;
    end else begin
      stateReg   <= stateNext;
      ptrReg     <= ptrNext;
      runCntReg  <= runCntNext;
      progLenReg <= progLenNext;
      addrReg    <= addrNext;
      wDatReg    <= wDatNext;
      wEnReg     <= wEnNext;
      workingReg <= workingNext;
      busyReg    <= busyNext;
      doneReg    <= doneNext;
      errReg     <= errNext;
      sumReg     <= sumNext;
    end
  end

  always_comb begin
    stateNext = stateReg;
    case (stateReg)
      IDLE:    if (start) stateNext = LOAD;
      LOAD:    if (handshake && lastWord) stateNext = FLUSH;
      FLUSH:   stateNext = RUN;
      RUN:     if (runEnd) stateNext = DONE;
      DONE:    stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  always_comb begin
    ptrNext     = ptrReg;
    runCntNext  = runCntReg;
    progLenNext = progLenReg;
    addrNext    = addrReg;
    wDatNext    = wDatReg;
    wEnNext     = 1'b0;
    workingNext = workingReg;
    doneNext    = 1'b0;
    errNext     = errReg;
    sumNext     = sumReg;
    busyNext    = (stateNext != IDLE);
    case (stateReg)
      IDLE: begin
        if (start) begin
          ptrNext     = '0;
          progLenNext = '0;
          errNext     = 1'b0;
          sumNext     = '0;
        end
      end
      LOAD: begin
        if (handshake) begin
          addrNext    = ptrReg[ADDR_W-1:0];
          wDatNext    = in_data;
          wEnNext     = 1'b1;
          ptrNext     = ptrReg + PTR_W'(1);
          progLenNext = ptrReg + PTR_W'(1);
          sumNext     = sumReg ^ in_data;
          if (atCap && !in_last) errNext = 1'b1;
        end
      end
      // Final write is still on the bus this cycle; working only rises after it retires.
      FLUSH: begin
        workingNext = 1'b1;
        runCntNext  = '0;
      end
      RUN: begin
        runCntNext = runCntReg + PTR_W'(1);
        if (runEnd) begin
          workingNext = 1'b0;
          doneNext    = 1'b1;
        end
      end
      default: ;
    endcase
  end

  assign addr         = addrReg;
  assign wEn          = wEnReg;
  assign wDat         = wDatReg;
  assign working      = workingReg;
  assign busy         = busyReg;
  assign done         = doneReg;
  assign prog_len     = progLenReg;
  assign err_overflow = errReg;

`ifdef IMEM_LOAD_CHECKSUM_EN
  assign checksum = sumReg;
`else
  logic unusedSum;
  assign unusedSum = ^sumReg;
`endif

endmodule

// File: doc/imem_load_sequencer.md
Name: imem_load_sequencer

Overview:
- Controller that sequences the processor core.
- Accepts a program as a valid/ready word stream from a host and writes it into instruction memory through the core's addr/wEn/wDat port. It then raises working for a bounded run window, drops it, and reports done.
- Replaces the hand-timed load-then-run sequencing, so the core never sees wEn and working asserted together.

Parameters:
- ADDR_W, 9, instruction memory address width; matches the core's addr port.
- DEPTH, 512, number of instruction words; must be ≤ 2**ADDR_W.
- RUN_EXTRA, 2, cycles working stays high beyond the loaded word count.

Ports:
- clock  in  1  system clock (50 MHz)
- reset_n  in  1  asynchronous active-low reset
- start  in  1  single-cycle request to begin load; honoured only in IDLE
- in_valid  in  1  host word valid
- in_ready  out  1  sequencer can accept a word
- in_data  in  32  instruction word, format {op[31:24], rA[23:20], rB[19:16], imm[15:0]}
- in_last  in  1  marks final word of program
- addr  out  ADDR_W  instruction memory write address, to core
- wEn  out  1  instruction memory write enable, to core
- wDat  out  32  instruction memory write data, to core
- working  out  1  core run enable
- busy  out  1  high in any state other than IDLE
- done  out  1  one-cycle pulse when the run window ends
- prog_len  out  ADDR_W+1  words written by the last load; holds until next start
- err_overflow  out  1  sticky; set when DEPTH words are loaded without in_last; cleared on start

Behaviour:
- Reset (asynchronous, immediate):
  - state=IDLE.
  - in_ready, wEn, working, busy, done, err_overflow all 0.
  - addr=0, wDat=0, prog_len=0, internal pointer and run counter 0.
  - Reset during LOAD or RUN aborts at once: working and wEn fall without waiting for a clock edge.
- All outputs are registered except in_ready, which is decoded from state (1 only in LOAD).
- States: IDLE → LOAD → FLUSH → RUN → DONE → IDLE.
- IDLE:
  - Outputs quiet. start=1 → LOAD.
  - Entering LOAD: ptr=0, prog_len=0, err_overflow=0.
- LOAD:
  - Handshake = in_valid & in_ready.
  - On each handshake edge: addr<=ptr, wDat<=in_data, wEn<=1, ptr<=ptr+1, prog_len<=ptr+1.
  - Cycle without a handshake: wEn<=0, addr/wDat hold.
  - Write latency: word accepted at edge k is presented to the core (wEn=1) during cycle k+1.
  - Handshake with in_last=1 → FLUSH.
  - Handshake at ptr==DEPTH-1 with in_last=0 → err_overflow<=1, treated as last → FLUSH.
  - start is ignored while busy.
- FLUSH:
  - Exactly one cycle; in_ready=0.
  - wEn is 1 for the final word during this cycle; the next edge clears wEn and sets working<=1, run counter<=0 → RUN.
- RUN:
  - working=1, wEn=0; run counter increments each cycle.
  - When counter == prog_len + RUN_EXTRA - 1 → working<=0, done<=1 → DONE.
  - working is therefore high for exactly prog_len + RUN_EXTRA cycles.
- DONE: one cycle, done=1; next edge done<=0 → IDLE.
- Invariant: wEn & working never both 1 in any cycle.
- Host side: in_valid with in_ready=0 has no effect; the host must hold the word until accepted.
- Arithmetic: prog_len and the run compare use ADDR_W+1 bits; the pointer does not wrap (DEPTH cap).

Optional Feature:
- Macro: IMEM_LOAD_CHECKSUM_EN.
- Defined:
  - Extra output port checksum (out, 32): XOR of all words accepted in the current load.
  - Cleared to 0 on reset and on entering LOAD; updated on each handshake edge; holds after LOAD.
- Undefined: port and logic absent; all other behaviour identical.

Test Plan:
- Basic load/run:
  - Stimulus: reset, then start; stream 1000001c,1001001d,1002001e,1003001f,10040020,10050021,20100000,21320000,32450000 with in_valid held high, in_last on the 9th word.
  - Response: addr 0..8 with wEn=1 on 9 consecutive cycles, wDat matching each word; FLUSH; working=1 for exactly 11 cycles; done pulse; prog_len=9; err_overflow=0.
- Host gaps:
  - Stimulus: same program with in_valid deasserted every other cycle.
  - Response: wEn=1 only in the cycles after handshakes; addr never skips; same run length of 11.
- Overflow:
  - Stimulus: DEPTH=4, stream 6 words with no in_last.
  - Response: 4 words written (addr 0..3); err_overflow=1; in_ready=0 after the 4th handshake; working for 6 cycles.
- Reset mid-run:
  - Stimulus: deassert reset_n asynchronously in the 3rd RUN cycle.
  - Response: working=0 and busy=0 immediately; after release, start=1 begins a clean load with prog_len=0.
- Start while busy:
  - Stimulus: pulse start during LOAD and during RUN.
  - Response: no state change, no restart, done pulses once.
- Checksum (IMEM_LOAD_CHECKSUM_EN defined):
  - Stimulus: load words 00000001, 00000003, in_last on the 2nd.
  - Response: checksum=00000002.
